pc_fetch_unit: RTL and testbench

- IF-stage program-counter and fetch sequencer of the 5-stage RV32I pipeline.
- Consumes BJ_SIG and the resolved target from the EX-stage branch control unit and redirects the PC.
- Issues word reads to instruction memory and absorbs memory busywait and hazard stalls.
- Presents the fetched instruction and its PC to the IF/ID register, and generates the flush that squashes wrong-path instructions.

---
 rtl/pc_fetch_unit_if.sv | 26 ++
 rtl/pc_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// IF-stage fetch bus: redirect, stall and instruction-memory signals, plus the IF/ID outputs.
// The master side is the fetch unit; the slave side is the pipeline/memory environment.
interface pc_fetch_unit_if;
  logic        BJ_SIG;
  logic [31:0] BJ_TARGET;
  logic        STALL;
  logic        IMEM_BUSYWAIT;
  logic [31:0] IMEM_READDATA;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTR;
  logic        IF_VALID;
  logic        FLUSH;
  logic        MISALIGN_FAULT;

  modport master (
    input  BJ_SIG, BJ_TARGET, STALL, IMEM_BUSYWAIT, IMEM_READDATA,
    output IMEM_ADDR, IMEM_READ, IF_PC, IF_INSTR, IF_VALID, FLUSH, MISALIGN_FAULT
  );

  modport slave (
    output BJ_SIG, BJ_TARGET, STALL, IMEM_BUSYWAIT, IMEM_READDATA,
    input  IMEM_ADDR, IMEM_READ, IF_PC, IF_INSTR, IF_VALID, FLUSH, MISALIGN_FAULT
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// RV32I IF-stage PC register and fetch sequencer with redirect, busywait and stall handling.
// Optional misaligned-target pulse is built only when PC_MISALIGN_CHECK_EN is defined.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  pc_fetch_unit_if.master bus
);

  localparam int          CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        if_pc_q, if_pc_d;
  logic [31:0]        if_instr_q, if_instr_d;
  logic               if_valid_q, if_valid_d;
  logic               pend_q, pend_d;
  logic [31:0]        pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               flush_q, flush_d;
  logic               imem_read_q, imem_read_d;
  logic               redirect_s;
  logic [31:0]        tgt_aligned_s;

  assign tgt_aligned_s = bus.BJ_TARGET & 32'hFFFF_FFFC;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    redirect_s = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH, ST_WAIT: begin
        if (bus.BJ_SIG) begin
          // An in-flight read must finish at the old PC; the target waits in pend_tgt.
          redirect_s = 1'b1;
          if_valid_d = 1'b0;
          if (bus.IMEM_BUSYWAIT) begin
            pend_d     = 1'b1;
            pend_tgt_d = tgt_aligned_s;
            state_d    = ST_WAIT;
          end else begin
            pc_d    = tgt_aligned_s;
            pend_d  = 1'b0;
            state_d = ST_FETCH;
          end
        end else if (bus.IMEM_BUSYWAIT) begin
          if_valid_d = 1'b0;
          state_d    = ST_WAIT;
        end else if (pend_q) begin
          pc_d       = pend_tgt_q;
          pend_d     = 1'b0;
          if_valid_d = 1'b0;
          state_d    = bus.STALL ? ST_HOLD : ST_FETCH;
        end else if (bus.STALL) begin
          state_d = ST_HOLD;
        end else begin
          if_instr_d = bus.IMEM_READDATA;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
          state_d    = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (bus.BJ_SIG) begin
          redirect_s = 1'b1;
          if_valid_d = 1'b0;
          pc_d       = tgt_aligned_s;
          pend_d     = 1'b0;
          state_d    = ST_FETCH;
        end else if (bus.STALL) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Flush countdown: reloaded by every redirect, frozen while the pipe is held.
  always_comb begin
    if (redirect_s) begin
      flush_cnt_d = CNT_W'(FLUSH_CYCLES);
    end else if (state_d == ST_HOLD) begin
      flush_cnt_d = flush_cnt_q;
    end else if (flush_cnt_q != {CNT_W{1'b0}}) begin
      flush_cnt_d = flush_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    flush_d     = (flush_cnt_d != {CNT_W{1'b0}});
    imem_read_d = (state_d == ST_FETCH) || (state_d == ST_WAIT);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VECTOR;
      if_pc_q     <= 32'h0000_0000;
      if_instr_q  <= NOP;
      if_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= 32'h0000_0000;
      flush_cnt_q <= {CNT_W{1'b0}};
      flush_q     <= 1'b0;
      imem_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      if_valid_q  <= if_valid_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      flush_cnt_q <= flush_cnt_d;
      flush_q     <= flush_d;
      imem_read_q <= imem_read_d;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    if (redirect_s && (bus.BJ_TARGET[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end else begin
      misalign_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign bus.MISALIGN_FAULT = misalign_q;
`else
  assign bus.MISALIGN_FAULT = 1'b0;
`endif

  assign bus.IMEM_ADDR = pc_q;
  assign bus.IMEM_READ = imem_read_q;
  assign bus.IF_PC     = if_pc_q;
  assign bus.IF_INSTR  = if_instr_q;
  assign bus.IF_VALID  = if_valid_q;
  assign bus.FLUSH     = flush_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed table, corner sequences, random vs reference model.
module tb_pc_fetch_unit;

  logic CLK = 1'b0;
  logic RESET;
  int   checks   = 0;
  int   failures = 0;

  pc_fetch_unit_if bus();

  pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  always_comb bus.IMEM_READDATA = mem_word(bus.IMEM_ADDR);

  // Reference model: the pipe is booting, held by a stall, or issuing reads.
  bit          m_boot, m_held, m_pend, m_valid, m_mis;
  logic [31:0] m_pc, m_ptgt, m_ifpc, m_instr;
  int          m_flush;

  task automatic model_step(input bit rst_n, input bit bj, input logic [31:0] tgt,
                            input bit stall, input bit busyw);
    bit reading, busy, freeze;
    if (!rst_n) begin
      m_boot = 1; m_held = 0; m_pend = 0; m_valid = 0; m_mis = 0;
      m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0000_0013; m_flush = 0;
    end else if (m_boot) begin
      m_boot = 0; m_mis = 0;
    end else begin
      reading = !m_held;
      busy    = reading && busyw;
      m_mis   = 0;
      if (bj) begin
        m_valid = 0; m_flush = 2; m_held = 0;
`ifdef PC_MISALIGN_CHECK_EN
        m_mis = (tgt % 4) != 0;
`endif
        if (busy) begin
          m_pend = 1; m_ptgt = tgt & 32'hFFFF_FFFC;
        end else begin
          m_pc = tgt & 32'hFFFF_FFFC; m_pend = 0;
        end
      end else begin
        freeze = 0;
        if (busy) begin
          m_valid = 0;
        end else if (reading && m_pend) begin
          m_pc = m_ptgt; m_pend = 0; m_valid = 0; m_held = stall; freeze = stall;
        end else if (stall) begin
          m_held = 1; freeze = 1;
        end else begin
          if (reading) begin
            m_ifpc = m_pc; m_instr = mem_word(m_pc); m_valid = 1; m_pc = m_pc + 32'd4;
          end
          m_held = 0;
        end
        if (!freeze && m_flush > 0) m_flush--;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst_n, input bit bj, input logic [31:0] tgt,
                       input bit stall, input bit busyw);
    RESET             = rst_n;
    bus.BJ_SIG        = bj;
    bus.BJ_TARGET     = tgt;
    bus.STALL         = stall;
    bus.IMEM_BUSYWAIT = busyw;
    @(posedge CLK);
    model_step(rst_n, bj, tgt, stall, busyw);
    #1;
    chk("model_addr",     bus.IMEM_ADDR, m_pc);
    chk("model_read",     32'(bus.IMEM_READ), 32'(!m_boot && !m_held));
    chk("model_if_pc",    bus.IF_PC, m_ifpc);
    chk("model_if_instr", bus.IF_INSTR, m_instr);
    chk("model_if_valid", 32'(bus.IF_VALID), 32'(m_valid));
    chk("model_flush",    32'(bus.FLUSH), 32'(m_flush != 0));
    chk("model_misalign", 32'(bus.MISALIGN_FAULT), 32'(m_mis));
  endtask

  typedef struct {
    bit          rst_n;
    bit          bj;
    logic [31:0] tgt;
    bit          stall;
    bit          busy;
    logic [31:0] e_addr;
    bit          e_read;
    bit          e_valid;
    logic [31:0] e_ifpc;
    bit          e_flush;
  } vec_t;

  vec_t        tbl[10];
  logic [31:0] frozen;
  bit          exp_mis;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0};
    tbl[2] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h4,   1'b1, 1'b1, 32'h0,   1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h8,   1'b1, 1'b1, 32'h4,   1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'hC,   1'b1, 1'b1, 32'h8,   1'b0};
    tbl[6] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 1'b1, 32'hC,   1'b0};
    tbl[7] = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 32'hC,   1'b1};
    tbl[8] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b1, 1'b1, 32'h100, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h108, 1'b1, 1'b1, 32'h104, 1'b0};

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rst_n, tbl[i].bj, tbl[i].tgt, tbl[i].stall, tbl[i].busy);
      chk("tbl_addr",  bus.IMEM_ADDR, tbl[i].e_addr);
      chk("tbl_read",  32'(bus.IMEM_READ), 32'(tbl[i].e_read));
      chk("tbl_valid", 32'(bus.IF_VALID), 32'(tbl[i].e_valid));
      chk("tbl_if_pc", bus.IF_PC, tbl[i].e_ifpc);
      chk("tbl_flush", 32'(bus.FLUSH), 32'(tbl[i].e_flush));
      if (tbl[i].e_valid) chk("tbl_instr", bus.IF_INSTR, mem_word(tbl[i].e_ifpc));
    end

    // Busywait at 0x20 with a redirect to 0x80 landing in wait cycle 2.
    drive(1, 1, 32'h20, 0, 0);
    drive(1, 0, 32'h0, 0, 1);
    chk("bw_addr_w1", bus.IMEM_ADDR, 32'h20);
    drive(1, 1, 32'h80, 0, 1);
    chk("bw_addr_w2", bus.IMEM_ADDR, 32'h20);
    chk("bw_flush",   32'(bus.FLUSH), 32'd1);
    drive(1, 0, 32'h0, 0, 1);
    chk("bw_addr_w3", bus.IMEM_ADDR, 32'h20);
    drive(1, 0, 32'h0, 0, 0);
    chk("bw_addr_tgt", bus.IMEM_ADDR, 32'h80);
    chk("bw_dropped",  32'(bus.IF_VALID), 32'd0);
    drive(1, 0, 32'h0, 0, 0);
    chk("bw_if_pc",    bus.IF_PC, 32'h80);
    chk("bw_valid",    32'(bus.IF_VALID), 32'd1);

    // Stall at 0x40; a redirect to 0x200 in stall cycle 3 wins.
    drive(1, 1, 32'h40, 0, 0);
    drive(1, 0, 32'h0, 0, 0);
    drive(1, 1, 32'h40, 0, 0);
    frozen = bus.IF_INSTR;
    drive(1, 0, 32'h0, 1, 0);
    drive(1, 0, 32'h0, 1, 0);
    chk("st_addr",   bus.IMEM_ADDR, 32'h40);
    chk("st_instr",  bus.IF_INSTR, frozen);
    chk("st_read",   32'(bus.IMEM_READ), 32'd0);
    drive(1, 1, 32'h200, 1, 0);
    chk("st_redirect", bus.IMEM_ADDR, 32'h200);
    chk("st_flush",    32'(bus.FLUSH), 32'd1);
    drive(1, 0, 32'h0, 1, 0);
    drive(1, 0, 32'h0, 0, 0);

    // Wrap from the top of the address space, then reset during a pending redirect.
    drive(1, 1, 32'hFFFF_FFFC, 0, 0);
    drive(1, 0, 32'h0, 0, 0);
    chk("wrap_addr",  bus.IMEM_ADDR, 32'h0);
    chk("wrap_if_pc", bus.IF_PC, 32'hFFFF_FFFC);
    drive(1, 0, 32'h0, 0, 1);
    drive(1, 1, 32'h300, 0, 1);
    drive(0, 0, 32'h0, 0, 1);
    chk("rst_addr",  bus.IMEM_ADDR, 32'h0);
    chk("rst_valid", 32'(bus.IF_VALID), 32'd0);
    chk("rst_flush", 32'(bus.FLUSH), 32'd0);
    chk("rst_instr", bus.IF_INSTR, 32'h0000_0013);
    drive(1, 0, 32'h0, 0, 0);
    drive(1, 0, 32'h0, 0, 0);
    chk("rst_no_pend", bus.IF_PC, 32'h0);
    chk("rst_addr4",   bus.IMEM_ADDR, 32'h4);

    // Misaligned target: PC aligned, fault pulse only when the check is built.
`ifdef PC_MISALIGN_CHECK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    drive(1, 1, 32'h102, 0, 0);
    chk("mis_addr",  bus.IMEM_ADDR, 32'h100);
    chk("mis_pulse", 32'(bus.MISALIGN_FAULT), 32'(exp_mis));
    drive(1, 0, 32'h0, 0, 0);
    chk("mis_clear", 32'(bus.MISALIGN_FAULT), 32'd0);
    drive(1, 1, 32'h207, 0, 0);
    chk("mis_again", 32'(bus.MISALIGN_FAULT), 32'(exp_mis));

    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 5) == 0, $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
